// File: rtl/fpu_pkg.sv
// Shared single-precision types, constants and classification helpers,
// plus the constant function that builds the reciprocal ROM contents.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  // Exponent 0 covers both zero and denormals; denormals flush to zero.
  function automatic logic is_zero(input float_t f);
    return f.exp == 8'h00;
  endfunction

  function automatic logic is_inf(input float_t f);
    return (f.exp == EXP_MAX) && (f.man == 23'd0);
  endfunction

  function automatic logic is_nan(input float_t f);
    return (f.exp == EXP_MAX) && (f.man != 23'd0);
  endfunction

  // Fraction part of 2/(1+m) - 1 for m = k * 2^-23.
  // Scaled by 2^(23+16), i.e. 16 extra fraction bits below the mantissa LSB.
  function automatic longint recip_frac(input longint k);
    longint one;
    one = longint'(1) <<< 23;
    return ((one - k) <<< 39) / (one + k);
  endfunction

  // One ROM word {a[22:0], b[12:0]} for interval idx.
  // Line through the interval end points (secant), with b in units of
  // 2^-12 mantissa LSB per d step. The intercept is lowered by half of the
  // secant's midpoint error so the convex-curve error is centred on zero,
  // and floored so it balances the truncation of b*d in the datapath.
  function automatic logic [35:0] rom_entry(input int idx, input int tbl_bits);
    longint k0, k1, km, f0, f1, fm, err, a, b;
    int     dbits;
    dbits = 23 - tbl_bits;
    k0    = longint'(idx) <<< dbits;
    k1    = longint'(idx + 1) <<< dbits;
    km    = k0 + (longint'(1) <<< (dbits - 1));
    f0    = recip_frac(k0);
    f1    = recip_frac(k1);
    fm    = recip_frac(km);
    err   = (f0 + f1) / 2 - fm;
    b     = (f0 - f1 + (longint'(1) <<< (dbits + 3))) >>> (dbits + 4);
    a     = (f0 - err / 2) >>> 16;
    if (a > 64'sd8388607) a = 64'sd8388607;
    if (a < 64'sd0)       a = 64'sd0;
    if (b > 64'sd8191)    b = 64'sd8191;
    return {a[22:0], b[12:0]};
  endfunction

endpackage

// File: rtl/finv_core.sv
// Combinational reciprocal of a single-precision divisor: ROM lookup on the
// leading mantissa bits plus linear interpolation on the remaining bits.
// The exponent is returned wide and signed so huge divisors do not wrap.
module finv_core
  import fpu_pkg::*;
#(
  parameter int TBL_BITS = 10
) (
  input  logic              [7:0]  ey,
  input  logic              [22:0] my,
  output logic signed       [9:0]  e_inv,
  output logic              [22:0] m_inv
);

  localparam int D_BITS   = 23 - TBL_BITS;
  localparam int ROM_SIZE = 1 << TBL_BITS;

  logic [35:0] rom [ROM_SIZE];

  for (genvar g = 0; g < ROM_SIZE; g++) begin : g_rom
    localparam logic [35:0] ENTRY = rom_entry(g, TBL_BITS);
    assign rom[g] = ENTRY;
  end

  logic [TBL_BITS-1:0] idx;
  logic [D_BITS-1:0]   d;
  logic [22:0]         a;
  logic [12:0]         b;
  logic [D_BITS:0]     bd_scaled;
  logic [23:0]         diff;

  // Interpolate a - b*d; a negative difference (last interval) saturates to 0.
  // my == 0 is an exact power of two: mantissa 0 and one more exponent step.
  always_comb begin
    idx       = my[22:D_BITS];
    d         = my[D_BITS-1:0];
    a         = rom[idx][35:13];
    b         = rom[idx][12:0];
    bd_scaled = (D_BITS + 1)'(({{D_BITS{1'b0}}, b} * {13'd0, d}) >> 12);
    diff      = {1'b0, a} - {{(23 - D_BITS){1'b0}}, bd_scaled};
    m_inv     = diff[23] ? 23'd0 : diff[22:0];
    e_inv     = 10'sd253 - $signed({2'b00, ey});
    if (my == 23'd0) begin
      m_inv = 23'd0;
      e_inv = 10'sd254 - $signed({2'b00, ey});
    end
  end

endmodule

// File: rtl/fdiv_pipe.sv
// Two-stage single-precision divider z = x * (1/y).
// Stage 1 forms the reciprocal of y; stage 2 multiplies, rounds to nearest
// even and resolves special cases from the original operands.
// Handshake: in_valid qualifies x/y on the sampling edge; out_valid qualifies
// z exactly LAT edges later. There is no ready/backpressure; one op per cycle.
module fdiv_pipe
  import fpu_pkg::*;
#(
  parameter int LAT      = 2,
  parameter int TBL_BITS = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        out_valid,
  output logic [31:0] z
);

  logic signed [9:0] e_inv;
  logic [22:0]       m_inv;

  finv_core #(.TBL_BITS(TBL_BITS)) u_finv (
    .ey    (y[30:23]),
    .my    (y[22:0]),
    .e_inv (e_inv),
    .m_inv (m_inv)
  );

  logic [LAT-1:0]    valid_sr;
  logic [31:0]       s1_x;
  logic [31:0]       s1_y;
  logic signed [9:0] s1_e_inv;
  logic [22:0]       s1_m_inv;
  logic [31:0]       z_next;

  float_t             fx, fy;
  logic [47:0]        prod;
  logic               norm, guard, sticky, round_up, carry, sign;
  logic [22:0]        mant;
  logic [23:0]        mant_r;
  logic signed [10:0] exp_sum;

  assign fx        = s1_x;
  assign fy        = s1_y;
  assign out_valid = valid_sr[LAT-1];

  // Pipeline registers; y travels with its reciprocal for special-case checks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_sr <= '0;
      s1_x     <= 32'd0;
      s1_y     <= 32'd0;
      s1_e_inv <= 10'sd0;
      s1_m_inv <= 23'd0;
      z        <= 32'd0;
    end else begin
      valid_sr <= {valid_sr[LAT-2:0], in_valid};
      if (in_valid) begin
        s1_x     <= x;
        s1_y     <= y;
        s1_e_inv <= e_inv;
        s1_m_inv <= m_inv;
      end
      if (valid_sr[0]) z <= z_next;
    end
  end

  // Multiply, normalise by one bit, round to nearest even, then select specials.
  always_comb begin
    prod = {24'd0, 1'b1, fx.man} * {24'd0, 1'b1, s1_m_inv};
    norm = prod[47];
    if (norm) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    carry    = mant_r[23];
    exp_sum  = {3'b000, fx.exp} + {s1_e_inv[9], s1_e_inv} - 11'(BIAS)
             + {10'd0, norm} + {10'd0, carry};
    sign     = fx.sign ^ fy.sign;

    z_next = {sign, exp_sum[7:0], mant_r[22:0]};
    if (is_nan(fx) || is_nan(fy))
      z_next = QNAN;
    else if ((is_zero(fx) && is_zero(fy)) || (is_inf(fx) && is_inf(fy)))
      z_next = QNAN;
    else if (is_zero(fy) || is_inf(fx))
      z_next = {sign, EXP_MAX, 23'd0};
    else if (is_inf(fy) || is_zero(fx))
      z_next = {sign, 31'd0};
    else if (exp_sum > 11'sd254)
      z_next = {sign, EXP_MAX, 23'd0};
    else if (exp_sum < 11'sd1)
      z_next = {sign, 31'd0};
  end

endmodule

// File: tb/tb_fdiv_pipe.sv
// Directed and random stimulus for fdiv_pipe with a queue-based scoreboard.
module tb_fdiv_pipe;

  // Queue word: {due_cycle[31:0], approx, x[31:0], y[31:0], expected[31:0]}
  localparam int W = 129;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] x, y, z;
  logic        out_valid;

  fdiv_pipe #(.LAT(2), .TBL_BITS(10)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .z         (z)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- reference helpers ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'd0) return 0.0;
    b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic real ulp_of(input real q);
    logic [63:0] b;
    b = $realtobits(q);
    return $bitstoreal({1'b0, b[62:52] - 11'd23, 52'd0});
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s got=%h want=%h", tag, obs, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] xv, input logic [31:0] yv,
                       input logic approx, input logic [31:0] ev);
    @(negedge clk);
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    exp_q.push_back({32'(cyc + 2), approx, xv, yv, ev});
  endtask

  task automatic drive_unscored(input logic [31:0] xv, input logic [31:0] yv);
    @(negedge clk);
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain pending=%0d want=0", exp_q.size());
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    real q, zr, err;
    if (rstn) begin
      if (out_valid) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_out got=%h want=no_output", z);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check32("latency", 32'(cyc), e[128:97]);
          if (e[96]) begin
            q   = f2r(e[95:64]) / f2r(e[63:32]);
            zr  = f2r(z);
            err = (zr > q) ? (zr - q) : (q - zr);
            err = err / ulp_of(q);
            n_vec++;
            assert (err <= 4.0) else begin
              n_fail++;
              $error("FAIL approx x=%h y=%h got=%h err_ulp=%f want<=4", e[95:64], e[63:32], z, err);
            end
          end else begin
            check32("exact", z, e[31:0]);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0][128:97] < 32'(cyc)) begin
        e = exp_q.pop_front();
        n_vec++;
        n_fail++;
        $error("FAIL missing_out x=%h y=%h got=no_output want=%h", e[95:64], e[63:32], e[31:0]);
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] xv, yv;
    logic [7:0]  ex, ey;
    logic        sx, sy;
    rstn     = 1'b0;
    in_valid = 1'b0;
    x        = 32'd0;
    y        = 32'd0;
    repeat (2) @(negedge clk);
    check32("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check32("reset_z", z, 32'd0);
    rstn = 1'b1;

    // Basic exact and approximate quotients.
    drive(32'h40C00000, 32'h40000000, 1'b0, 32'h40400000);
    drain();
    drive(32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB);
    drain();

    // Special operands.
    drive(32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000);
    drive(32'h00000000, 32'h00000000, 1'b0, 32'h7FC00000);
    drive(32'hBF800000, 32'h7F800000, 1'b0, 32'h80000000);
    drive(32'h3F800000, 32'h7FC00001, 1'b0, 32'h7FC00000);
    drive(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000);
    drive(32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000);
    drive(32'h80000000, 32'h40000000, 1'b0, 32'h80000000);
    // Range limits and denormal flush.
    drive(32'h7F000000, 32'h00800000, 1'b0, 32'h7F800000);
    drive(32'h00800000, 32'h7F000000, 1'b0, 32'h00000000);
    drive(32'h00400000, 32'h3F800000, 1'b0, 32'h00000000);
    drain();

    // Five back-to-back operations, results must emerge in order.
    drive(32'h40C00000, 32'h40000000, 1'b0, 32'h40400000);
    drive(32'hC1400000, 32'h40800000, 1'b0, 32'hC0400000);
    drive(32'h3FC00000, 32'h3F000000, 1'b0, 32'h40400000);
    drive(32'h41200000, 32'h41000000, 1'b0, 32'h3FA00000);
    drive(32'h40E00000, 32'hBF800000, 1'b0, 32'hC0E00000);
    drain();

    // Random x over power-of-two y: exact result expected.
    for (int i = 0; i < 16; i++) begin
      sx = 1'($urandom_range(0, 1));
      sy = 1'($urandom_range(0, 1));
      ex = 8'($urandom_range(100, 150));
      ey = 8'($urandom_range(110, 140));
      xv = {sx, ex, 23'($urandom)};
      yv = {sy, ey, 23'd0};
      drive(xv, yv, 1'b0, {sx ^ sy, ex - ey + 8'd127, xv[22:0]});
    end
    drain();

    // Random sweep covering every pairing of mx[22:18] and my[22:18].
    for (int i = 0; i < 1024; i++) begin
      xv = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 5'(i), 18'($urandom)};
      yv = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 5'(i >> 5), 18'($urandom)};
      drive(xv, yv, 1'b1, 32'd0);
    end
    drain();

    // Reset while two operations are in flight.
    drive_unscored(32'h40C00000, 32'h40000000);
    drive_unscored(32'h41200000, 32'h41000000);
    #1;
    rstn     = 1'b0;
    in_valid = 1'b0;
    #1;
    check32("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("async_rst_z", z, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fdiv_pipe.md
Name: fdiv_pipe

Overview:
- Single-precision IEEE-754 divider computing z = x / y as x × (1/y): a table-plus-linear-interpolation reciprocal followed by a floating-point multiply.
- Sits in the FPU execute path beside fadd/fmul.
- Two-stage pipeline, fully pipelined; accepts one operation per cycle.
- Approximate, not correctly rounded; the error bound is stated below.

Parameters:
- LAT, 2, fixed pipeline depth in cycles from in_valid to out_valid; only the value 2 is supported.
- TBL_BITS, 10, number of leading y-mantissa bits that index the reciprocal ROM (2^TBL_BITS entries).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  x and y are valid this cycle.
- x  in  32  dividend, IEEE single.
- y  in  32  divisor, IEEE single.
- out_valid  out  1  z is valid this cycle.
- z  out  32  quotient, IEEE single.

Behaviour:
- Reset (rstn low, asynchronous): all pipeline registers clear; out_valid=0, z=32'h0. Operations in flight are discarded. No output for them after rstn rises.
- Latency: in_valid sampled at edge N gives out_valid=1 at edge N+2. There is no backpressure. in_valid may be high every cycle.
- Stage 1 (reciprocal):
  - Index = my[22:23-TBL_BITS]; low bits d = my[22-TBL_BITS:0].
  - ROM entry holds {a[22:0], b[12:0]}, generated offline from the secant of 1/(1+m) over each interval.
  - Reciprocal mantissa = a − b·d, truncated to 23 bits.
  - Exponent = 253 − ey, or 254 − ey when my==0.
  - my==0 gives mantissa 0, so exact powers of two invert exactly.
  - Registers: yinv and x.
- Stage 2 (multiply):
  - Sign = sx ^ sy.
  - 24×24 product of hidden-bit mantissas; normalise by 1 bit.
  - Round to nearest-even.
  - Exponent = ex + e_inv − 127 (+1 on normalise).
  - Register z.
- Accuracy: for normal x, y and normal result, |z − x/y| ≤ 4 ulp of the exact quotient. When y is a power of two and the result is normal, z equals x/y exactly.
- Special cases. Exponent 0 is treated as ±0, i.e. denormal inputs flush to zero. NaN out is always canonical 32'h7FC00000. Sign of zero/inf results = sx^sy. Priority top-down:
  - Either operand NaN → NaN.
  - 0/0 or inf/inf → NaN.
  - x/0 (x nonzero or inf) → ±inf.
  - inf/y (y finite) → ±inf.
  - x/inf or 0/y → ±0.
  - Result exponent > 254 → ±inf (overflow).
  - Result exponent < 1 → ±0 (flush underflow).
- Stage-1 reciprocal of y with exponent ≥ 253 underflows. Special-case detection therefore uses the original y, which is carried alongside to stage 2.

Decomposition:
- Package fpu_pkg:
  - float_t struct {sign, exp[7:0], man[22:0]}.
  - Constants QNAN=32'h7FC00000, BIAS=127, EXP_MAX=8'hFF.
  - Classification helpers is_zero, is_inf, is_nan.
- Sub-module finv_core: combinational reciprocal plus ROM, instantiated in stage 1.
- The multiply/round logic stays inline in fdiv_pipe.

Test Plan:
- x=32'h40C00000 (6.0), y=32'h40000000 (2.0) → z=32'h40400000 (3.0) exactly, out_valid exactly 2 cycles after in_valid.
- x=32'h3F800000 (1.0), y=32'h40400000 (3.0) → z within ±4 ulp of 32'h3EAAAAAB; sweep 1024 randoms covering all 32 values of mx[22:18] and my[22:18] against the 4-ulp bound.
- Specials:
  - x=32'h3F800000, y=32'h00000000 → 32'h7F800000.
  - x=0, y=0 → 32'h7FC00000.
  - x=32'hBF800000, y=32'h7F800000 → 32'h80000000.
  - y=32'h7FC00001 → 32'h7FC00000.
- Range:
  - x=32'h7F000000, y=32'h00800000 → 32'h7F800000 (overflow).
  - x=32'h00800000, y=32'h7F000000 → 32'h00000000 (underflow flush).
  - x=32'h00400000 (denormal), y=1.0 → 32'h00000000.
- Back-to-back: in_valid high 5 consecutive cycles with distinct operands → 5 consecutive out_valid, results in order.
- Reset mid-operation: issue 2 operations, drop rstn for 1 cycle before they exit → out_valid=0 and z=0 immediately (asynchronously), no stale results afterwards.
